ids_bus_arbiter: RTL
====================

// Module: ids_bus_arbiter
// PURPOSE
//  Grant-side responder for the ids_bus request/grant handshake: the core data port (req/gnt_dmem) and
//  ids_dma (req/gnt_dma) are initiators; this block decides ownership of the shared data bus.
//  Registered grants, round-robin tie-break, starvation guard, one idle cycle between owners.
//  Sits inside ids_bus; its owner output drives the data-path mux toward the DMEM/BUF/UART/PIM slaves.
// PARAMETERS
//  MAX_HOLD  64                       cycles an owner may keep the bus while the other side requests; 0 = never preempt
//  HOLD_W    $clog2(MAX_HOLD+1)       width of the hold counter (derived, not overridden)
// PORTS
//  i_clk        in   1  clock; single clock domain
//  i_rst_n      in   1  reset, synchronous, active-low
//  i_req_dmem   in   1  core data port requests the bus; held high for the whole access
//  o_gnt_dmem   out  1  core owns the bus (registered)
//  i_req_dma    in   1  DMA requests the bus; held high for the whole burst
//  o_gnt_dma    out  1  DMA owns the bus (registered)
//  o_owner      out  2  2'b00 none, 2'b01 core, 2'b10 DMA; registered, equals {o_gnt_dma,o_gnt_dmem}
//  o_preempt    out  1  one-cycle pulse in the cycle a grant is revoked by the starvation guard
// BEHAVIOUR
//  - Reset (i_rst_n low at a clock edge): state IDLE, both gnt 0, o_owner 0, o_preempt 0, hold_cnt 0,
//    last_owner = DMA (core wins the first tie). Reset mid-burst drops the grant at the next edge, no handoff.
//  - States: IDLE, GNT_CORE, GNT_DMA. Grants are flops decoded from state; never both high.
//  - IDLE: no req -> IDLE. One req -> that grant at the next edge (req seen cycle t, gnt high t+1).
//    Both req -> grant the side that is NOT last_owner.
//  - GNT_X: X deasserts req in cycle t -> IDLE, gnt low in t+1; last_owner <= X.
//    Any pending request from the other side is granted in t+2 (exactly one idle cycle between owners).
//  - Starvation guard (MAX_HOLD>0): hold_cnt clears on grant entry. It increments each cycle in GNT_X while the
//    other req is high and saturates; it does not increment while the other req is low (count is paused).
//    When hold_cnt == MAX_HOLD-1 and the other req is still high -> IDLE next edge; o_preempt pulses that cycle
//    and last_owner <= X, so the other side wins in IDLE.
//    The preempted initiator keeps req high and treats the lost grant as a stall; it is regranted by round-robin.
//  - Simultaneous release by X and preempt condition in the same cycle: treated as a normal release; o_preempt stays 0.
//  - A req dropping before its grant arrives is legal; IDLE re-evaluates every cycle and no grant is issued.
//  - No combinational path from req to gnt. Arbitration latency is 1 cycle from IDLE and 2 cycles on a handover.
// STRUCTURE
//  - Shared ids_bus_pkg: typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DMA} bus_owner_e, plus the
//    arbiter state enum; ids_bus reuses bus_owner_e for its data-path mux select.
//  - One always_ff for state, last_owner, hold_cnt and o_preempt; one always_comb for next-state.
//    No sub-module; the hold counter is inline.
//  - Assertions: $onehot0({o_gnt_dma,o_gnt_dmem}); gnt implies the matching req was high in the previous cycle;
//    no owner change without an intervening IDLE cycle.
// TESTING
//  1. Reset, then i_req_dmem=1 at cycle 5 -> o_gnt_dmem=1 at 6, o_owner=01; req low at 9 -> gnt low at 10.
//  2. Both req high at cycle 3 right after reset -> core granted at 4. Core releases at 7 -> DMA granted at 9,
//     with o_owner=00 at cycle 8.
//  3. MAX_HOLD=4: DMA owns the bus, core req rises at cycle 10 and stays high -> o_preempt=1 at 13, DMA gnt low at 14,
//     core gnt at 15; DMA regranted 2 cycles after the core releases.
//  4. MAX_HOLD=0: DMA holds for 200 cycles with core requesting -> no preempt; core gnt 2 cycles after DMA release.
//  5. Reset asserted while o_gnt_dma=1 -> both gnt 0 at the next edge. After release both req high -> core granted first.
//  6. Random req toggling for 10k cycles with the assertions above enabled -> no assertion failures;
//     no requester waits more than MAX_HOLD+3 cycles.

Source files
------------

// File: rtl/ids_bus_pkg.sv
// ids_bus shared types: bus owner encoding and arbiter state.
// The owner encoding doubles as the data-path mux select in ids_bus.
package ids_bus_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_DMA  = 2'b10
  } bus_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'b00,
    ARB_GNT_CORE = 2'b01,
    ARB_GNT_DMA  = 2'b10
  } arb_state_e;

  function automatic bus_owner_e owner_of(input arb_state_e s);
    bus_owner_e o;
    o = OWN_NONE;
    case (s)
      ARB_GNT_CORE: o = OWN_CORE;
      ARB_GNT_DMA:  o = OWN_DMA;
      default:      o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ids_bus_arbiter.sv
// ids_bus grant-side arbiter between core data port and DMA.
// Registered grants, round-robin ties, starvation guard, idle gap.
module ids_bus_arbiter
  import ids_bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_dmem,
  output logic       o_gnt_dmem,
  input  logic       i_req_dma,
  output logic       o_gnt_dma,
  output logic [1:0] o_owner,
  output logic       o_preempt
);

  // MAX_HOLD=0 disables the guard; keep the counter 1 bit wide then.
  localparam int unsigned HOLD_W =
    (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned LAST_I =
    (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LAST_I);
  localparam bit GUARD_ON = (MAX_HOLD > 0);

  arb_state_e        state_q, state_d;
  bus_owner_e        last_owner_q, last_owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              gnt_dmem_q, gnt_dmem_d;
  logic              gnt_dma_q, gnt_dma_d;
  logic              own_req;
  logic              oth_req;
  logic              preempt;

  // Next-state: arbitration in IDLE, release/preempt while granted.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    preempt      = 1'b0;
    own_req      = 1'b0;
    oth_req      = 1'b0;

    unique case (state_q)
      ARB_GNT_CORE: begin
        own_req = i_req_dmem;
        oth_req = i_req_dma;
      end
      ARB_GNT_DMA: begin
        own_req = i_req_dma;
        oth_req = i_req_dmem;
      end
      default: begin
        own_req = 1'b0;
        oth_req = 1'b0;
      end
    endcase

    unique case (state_q)
      ARB_IDLE: begin
        hold_cnt_d = '0;
        if (i_req_dmem && i_req_dma) begin
          state_d = (last_owner_q == OWN_CORE) ?
                    ARB_GNT_DMA : ARB_GNT_CORE;
        end else if (i_req_dmem) begin
          state_d = ARB_GNT_CORE;
        end else if (i_req_dma) begin
          state_d = ARB_GNT_DMA;
        end
      end
      ARB_GNT_CORE, ARB_GNT_DMA: begin
        if (!own_req) begin
          state_d      = ARB_IDLE;
          last_owner_d = owner_of(state_q);
        end else if (GUARD_ON && oth_req &&
                     hold_cnt_q == HOLD_LAST) begin
          state_d      = ARB_IDLE;
          last_owner_d = owner_of(state_q);
          preempt      = 1'b1;
        end else if (oth_req && hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    gnt_dmem_d = (state_d == ARB_GNT_CORE);
    gnt_dma_d  = (state_d == ARB_GNT_DMA);
  end

  // State, round-robin memory, hold counter and grant flops.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWN_DMA;
      hold_cnt_q   <= '0;
      gnt_dmem_q   <= 1'b0;
      gnt_dma_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      gnt_dmem_q   <= gnt_dmem_d;
      gnt_dma_q    <= gnt_dma_d;
    end
  end

  assign o_gnt_dmem = gnt_dmem_q;
  assign o_gnt_dma  = gnt_dma_q;
  assign o_owner    = {gnt_dma_q, gnt_dmem_q};
  // Pulses in the decision cycle; the grant drops at the next edge.
  assign o_preempt  = preempt;

  a_onehot: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    $onehot0({o_gnt_dma, o_gnt_dmem}));

  a_gnt_core_req: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    o_gnt_dmem |-> $past(i_req_dmem));

  a_gnt_dma_req: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    o_gnt_dma |-> $past(i_req_dma));

  a_idle_gap: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    ($past(o_owner) != 2'b00 && o_owner != 2'b00)
      |-> (o_owner == $past(o_owner)));

endmodule
